bram_port_server: RTL

- Request/response adapter in front of one port of the team's dual-port byte-enable BRAM primitive (WRITE_FIRST, optional output pipeline register).
- Converts a valid/ready request stream into raw BRAM port drives (EN/WE/ADDR/DI).
- Tracks read latency and captures DO into a response FIFO.
- Uses credit-based flow control so no read data is lost under response backpressure.

---
 rtl/bram_port_server.sv | 110 +++++++++++
 1 files changed

// File: rtl/bram_port_server.sv
// Request/response adapter for one port of a byte-enable BRAM: issues EN/WE/ADDR/DI,
// tracks read latency and buffers DO in a credit-protected FIFO. Optional: BRAM_PORT_SERVER_BYPASS_EN.
module bram_port_server #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4,
  parameter int CHUNKSIZE  = 8,
  parameter int PIPELINED  = 0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [WE_WIDTH-1:0]   req_byteen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);
  localparam int LAT = 1 + PIPELINED;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = $clog2(RSP_DEPTH);

  if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_cfg
    $error("bram_port_server: DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
  end

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         fcnt;
  logic [LAT-1:0]        tag;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic acc, rd_acc, capture, pop, fifo_empty, fifo_pop, push, bypass;

  // Handshakes: a beat transfers on a cycle where valid & ready are both high; ready never
  // depends on valid, and valid/payload hold until the transfer.
  // Ready is pure credit: reads in flight plus FIFO occupancy can never exceed RSP_DEPTH.
  assign req_ready = RST_N && (cnt < CW'(RSP_DEPTH));
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~req_write;

  assign bram_en   = acc;
  assign bram_we   = req_write ? req_byteen : '0;
  assign bram_addr = req_addr;
  assign bram_di   = req_wdata;

  assign capture    = tag[LAT-1];
  assign fifo_empty = (fcnt == '0);

`ifdef BRAM_PORT_SERVER_BYPASS_EN
  assign bypass = capture & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign rsp_valid = ~fifo_empty | bypass;
  assign rsp_rdata = bypass ? bram_do : mem[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;
  assign fifo_pop  = pop & ~fifo_empty;
  // A bypassed capture that is taken immediately never occupies an entry.
  assign push      = capture & ~(bypass & rsp_ready);
  assign busy      = (cnt != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt    <= '0;
      fcnt   <= '0;
      tag    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      tag[0] <= rd_acc;
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];

      case ({rd_acc, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      if (push) begin
        mem[wr_ptr] <= bram_do;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, fifo_pop})
        2'b10:   fcnt <= fcnt + CW'(1);
        2'b01:   fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  always @(posedge CLK) begin
    if (RST_N && push && !fifo_pop && (fcnt == CW'(RSP_DEPTH)))
      $error("bram_port_server: response FIFO overflow");
  end
endmodule
